// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared parameters and lookahead helpers for the pipelined CLA adder
package cla_pkg;

  localparam int GROUP_DEFAULT = 4;
  localparam int MAX_GROUP     = 32;

  // Width of the slice each pipeline stage adds
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Fold per-bit generate/propagate (LSB first) into the group pair {G, P}
  function automatic logic [1:0] group_gp(input logic [MAX_GROUP-1:0] g,
                                          input logic [MAX_GROUP-1:0] p,
                                          input int n);
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int i = 0; i < MAX_GROUP; i++) begin
      if (i < n) begin
        gg = g[i] | (p[i] & gg);
        pp = pp & p[i];
      end
    end
    return {gg, pp};
  endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead cell
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c,
  output logic [GROUP-1:0] s,
  output logic             g_out,
  output logic             p_out
);

  logic [GROUP-1:0]     g;
  logic [GROUP-1:0]     p;
  logic [MAX_GROUP-1:0] g_ext;
  logic [MAX_GROUP-1:0] p_ext;
  logic [1:0]           gp;

  assign g     = a & b;
  assign p     = a ^ b;
  assign g_ext = MAX_GROUP'(g);
  assign p_ext = MAX_GROUP'(p);
  assign gp    = group_gp(g_ext, p_ext, GROUP);
  assign g_out = gp[1];
  assign p_out = gp[0];

  // Sum bits from the lookahead carry into each bit position
  always_comb begin
    logic carry;
    carry = c;
    s     = '0;
    for (int i = 0; i < GROUP; i++) begin
      s[i]  = p[i] ^ carry;
      carry = g[i] | (p[i] & carry);
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int GROUP  = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int S  = slice_width(WIDTH, STAGES);
  localparam int NG = S / GROUP;

  logic [WIDTH-1:0] bb_in;
  logic             c0_in;
  logic [STAGES:0]  ready;

  assign bb_in         = sub ? ~b : b;
  assign c0_in         = cin ^ sub;
  assign ready[STAGES] = out_ready;
  assign in_ready      = !rst && ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OPW = WIDTH - k * S;   // operand bits from this slice upward
    localparam int SW  = (k + 1) * S;     // result bits settled once this stage loads

    logic           v_in;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic           c_in;
    logic [SW-1:0]  sum_new;
    logic [S-1:0]   s_slice;
    logic           c_slice;
    logic           load;
    logic [NG-1:0]  grp_g;
    logic [NG-1:0]  grp_p;
    logic [NG-1:0]  grp_c;
    logic           v_q, v_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic           c_q, c_d;

    if (k == 0) begin : g_src
      assign v_in    = in_valid;
      assign op_a    = a;
      assign op_b    = bb_in;
      assign c_in    = c0_in;
      assign sum_new = s_slice;
    end else begin : g_src
      assign v_in    = g_stage[k-1].v_q;
      assign op_a    = g_stage[k-1].g_skew.a_q;
      assign op_b    = g_stage[k-1].g_skew.bb_q;
      assign c_in    = g_stage[k-1].c_q;
      assign sum_new = {s_slice, g_stage[k-1].sum_q};
    end

    assign ready[k] = !v_q || ready[k+1];
    assign load     = ready[k] && v_in;

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (op_a[j*GROUP +: GROUP]),
        .b     (op_b[j*GROUP +: GROUP]),
        .c     (grp_c[j]),
        .s     (s_slice[j*GROUP +: GROUP]),
        .g_out (grp_g[j]),
        .p_out (grp_p[j])
      );
    end

    // Second-level lookahead: carry into each group from the group G/P pairs
    always_comb begin
      logic carry;
      carry = c_in;
      grp_c = '0;
      for (int j = 0; j < NG; j++) begin
        grp_c[j] = carry;
        carry    = grp_g[j] | (grp_p[j] & carry);
      end
      c_slice = carry;
    end

    // Advance when the downstream slot frees up; data only moves with a valid beat
    always_comb begin
      v_d   = ready[k] ? v_in : v_q;
      sum_d = load ? sum_new : sum_q;
      c_d   = load ? c_slice : c_q;
    end

    // Stage valid, settled sum bits and slice carry-out
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else begin
        v_q   <= v_d;
        sum_q <= sum_d;
        c_q   <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [OPW-S-1:0] a_q, a_d;
      logic [OPW-S-1:0] bb_q, bb_d;

      // Operand bits for the slices still to be added ride along with the beat
      always_comb begin
        a_d  = load ? op_a[OPW-1:S] : a_q;
        bb_d = load ? op_b[OPW-1:S] : bb_q;
      end

      // Operand skew registers
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          bb_q <= '0;
        end else begin
          a_q  <= a_d;
          bb_q <= bb_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q, ovf_d;

      // Signed overflow: operands agree in sign but the result does not
      always_comb begin
        ovf_d = load ? ((op_a[S-1] == op_b[S-1]) && (s_slice[S-1] != op_a[S-1])) : ovf_q;
      end

      // Overflow flag travels with the final stage
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder at three sizes
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin_in, sub_in;
  logic [63:0] a_in, b_in;

  logic        ir0, ov0, co0, of0;
  logic [63:0] s0;
  logic        ir1, ov1, co1, of1;
  logic [31:0] s1;
  logic        ir2, ov2, co2, of2;
  logic [15:0] s2;

  pipelined_cla_adder #(.WIDTH(64), .STAGES(4), .GROUP(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
  );

  pipelined_cla_adder #(.WIDTH(16), .STAGES(1), .GROUP(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2)
  );

  typedef struct {
    logic [65:0] res;
    int          t;
    bit          lat;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];

  int n_err    = 0;
  int n_checks = 0;
  int n_cyc    = 0;
  bit lat_en   = 1'b0;
  int n_out[3] = '{0, 0, 0};
  int n_acc[3] = '{0, 0, 0};
  int stg[3]   = '{4, 2, 1};
  int wid[3]   = '{64, 32, 16};

  // Reference: unsigned and signed arithmetic on wide integers, result packed as {ovf, cout, sum}
  function automatic logic [65:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub, input int w);
    logic [71:0]        ua, ub, ur, mask, ci;
    logic signed [71:0] sa, sb, sr, smax, smin, sci;
    logic               co, ov;
    mask = (72'd1 << w) - 72'd1;
    ua   = {8'h0, a} & mask;
    ub   = {8'h0, b} & mask;
    sa   = $signed(ua << (72 - w)) >>> (72 - w);
    sb   = $signed(ub << (72 - w)) >>> (72 - w);
    ci   = {71'd0, cin};
    sci  = $signed(ci);
    smax = $signed((72'd1 << (w - 1)) - 72'd1);
    smin = -smax - 72'sd1;
    if (!sub) begin
      ur = ua + ub + ci;
      co = ur[w];
      sr = sa + sb + sci;
    end else begin
      ur = ua - ub - ci;
      co = (ua >= ub + ci);
      sr = sa - sb - sci;
    end
    ov = (sr > smax) || (sr < smin);
    ur = ur & mask;
    return {ov, co, ur[63:0]};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scb(input int d, input logic acc, input logic ov, input logic [65:0] obs);
    ent_t e;
    int   sz;
    case (d)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (ov) begin
      chk($sformatf("d%0d_out_backed_by_beat", d), 66'(sz != 0), 66'd1);
      if (sz != 0) begin
        case (d)
          0:       e = q0[0];
          1:       e = q1[0];
          default: e = q2[0];
        endcase
        chk($sformatf("d%0d_result", d), obs, e.res);
        if (out_ready) begin
          case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
          endcase
          n_out[d]++;
          if (e.lat) chk($sformatf("d%0d_latency", d), 66'(n_cyc - e.t), 66'(stg[d]));
        end
      end
    end
    if (acc) begin
      e.res = ref_model(a_in, b_in, cin_in, sub_in, wid[d]);
      e.t   = n_cyc;
      e.lat = lat_en;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
      n_acc[d]++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    n_cyc++;
    scb(0, in_valid && ir0, ov0, {of0, co0, s0});
    scb(1, in_valid && ir1, ov1, {of1, co1, 32'h0, s1});
    scb(2, in_valid && ir2, ov2, {of2, co2, 48'h0, s2});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a_in   = {$urandom, $urandom};
    b_in   = {$urandom, $urandom};
    cin_in = 1'($urandom_range(0, 1));
    sub_in = 1'($urandom_range(0, 1));
  endtask

  // Drive one beat, then count cycles until dut0 presents a result
  task automatic one_beat(input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sb, output int n);
    a_in = av; b_in = bv; cin_in = ci; sub_in = sb; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 1;
    while (!ov0 && n < 20) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int acc_b[3];
    int out_b[3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;

    // Reset held two cycles
    cycle();
    cycle();
    chk("rst_out_valid", 66'({ov0, ov1, ov2}), 66'd0);
    chk("rst_outputs", {of0, co0, s0}, 66'd0);
    chk("rst_in_ready", 66'({ir0, ir1, ir2}), 66'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 66'({ir0, ir1, ir2}), 66'b111);

    // All-ones + 1 ripple, latency
    lat_en = 1'b1;
    one_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, n);
    chk("ripple_latency", 66'(n), 66'd4);
    chk("ripple_result", {of0, co0, s0}, {1'b0, 1'b1, 64'h0});
    repeat (3) cycle();

    // Subtract cases
    one_beat(64'd5, 64'd7, 1'b0, 1'b1, n);
    chk("sub_5_7_latency", 66'(n), 66'd4);
    chk("sub_5_7_result", {of0, co0, s0}, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    repeat (3) cycle();
    one_beat(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, n);
    chk("sub_min_1_latency", 66'(n), 66'd4);
    chk("sub_min_1_result", {of0, co0, s0}, {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    repeat (3) cycle();

    // 200-beat random stream, no stalls
    for (int i = 0; i < 3; i++) out_b[i] = n_out[i];
    for (int i = 0; i < 200; i++) begin
      rand_beat();
      if (i % 25 == 0) begin
        a_in = '1; b_in = '0; cin_in = 1'b1; sub_in = 1'b0;
      end else if (i % 25 == 12) begin
        a_in = 64'h8000_0000_0000_8000; b_in = 64'd1; cin_in = 1'b0; sub_in = 1'b1;
      end
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("stream_d0_count", 66'(n_out[0] - out_b[0]), 66'd200);
    chk("stream_d1_count", 66'(n_out[1] - out_b[1]), 66'd200);
    chk("stream_d2_count", 66'(n_out[2] - out_b[2]), 66'd200);

    // Backpressure: out_ready low for 10 cycles from an empty pipeline
    lat_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_b[i] = n_acc[i];
      out_b[i] = n_out[i];
    end
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_beat();
      in_valid = 1'b1;
      cycle();
    end
    chk("bp_d0_accepted", 66'(n_acc[0] - acc_b[0]), 66'd4);
    chk("bp_d1_accepted", 66'(n_acc[1] - acc_b[1]), 66'd2);
    chk("bp_d2_accepted", 66'(n_acc[2] - acc_b[2]), 66'd1);
    chk("bp_in_ready_low", 66'({ir0, ir1, ir2}), 66'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (8) cycle();
    chk("bp_d0_drained", 66'(n_out[0] - out_b[0]), 66'd4);
    chk("bp_d1_drained", 66'(n_out[1] - out_b[1]), 66'd2);
    chk("bp_queues_empty", 66'(q0.size() + q1.size() + q2.size()), 66'd0);

    // Reset with 3 beats in flight
    lat_en   = 1'b1;
    out_b[0] = n_out[0];
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    chk("midrst_out_valid", 66'({ov0, ov1, ov2}), 66'd0);
    repeat (8) cycle();
    chk("midrst_d0_none_out", 66'(n_out[0] - out_b[0]), 66'd0);

    // Recovery stream after mid-operation reset
    for (int i = 0; i < 20; i++) begin
      rand_beat();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("final_queues_empty", 66'(q0.size() + q1.size() + q2.size()), 66'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
